// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM->WB stage.
// The lane record and skid state encoding live here so the stage, the
// forwarding network and the register-file port agree on one definition.
package mem_wb_pkg;

    localparam int unsigned MAX_LANES   = 4;
    localparam int unsigned LANE_DATA_W = 32;
    localparam int unsigned LANE_REG_AW = 5;

    // Architectural zero register; writes to it are dropped.
    localparam int unsigned REG_ZERO = 0;

    // One write-back slot at the core's default widths.
    typedef struct packed {
        logic [LANE_DATA_W-1:0] wdata;
        logic [LANE_REG_AW-1:0] waddr;
        logic                   wen;
        logic                   mul_en;
    } lane_t;

    // Occupancy of the two-entry skid variant (main register, skid register).
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_e;

    function automatic logic lanes_in_range(input int unsigned lanes);
        return (lanes >= 1) && (lanes <= MAX_LANES);
    endfunction

endpackage

// File: rtl/mem_wb_stage_n_if.sv
// MEM->WB bundle bus: upstream handshake, flush, downstream handshake and
// per-lane write-back fields. master = surrounding pipeline, slave = stage.
interface mem_wb_stage_n_if #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) ();

    logic                     mem_valid;
    logic                     mem_allowin;
    logic                     flush;
    logic                     wb_allowin;
    logic [LANES*DATA_W-1:0]  mem_wdata;
    logic [LANES*REG_AW-1:0]  mem_waddr;
    logic [LANES-1:0]         mem_wen;
    logic [LANES-1:0]         mem_mul_en;
    logic                     wb_valid;
    logic [LANES*DATA_W-1:0]  wb_wdata;
    logic [LANES*REG_AW-1:0]  wb_waddr;
    logic [LANES-1:0]         wb_wen;
    logic [LANES-1:0]         wb_mul_en;

    modport master (
        output mem_valid, flush, wb_allowin, mem_wdata, mem_waddr, mem_wen, mem_mul_en,
        input  mem_allowin, wb_valid, wb_wdata, wb_waddr, wb_wen, wb_mul_en
    );

    modport slave (
        input  mem_valid, flush, wb_allowin, mem_wdata, mem_waddr, mem_wen, mem_mul_en,
        output mem_allowin, wb_valid, wb_wdata, wb_waddr, wb_wen, wb_mul_en
    );

endinterface

// File: rtl/mem_wb_lane_qual.sv
// Per-lane write-enable qualification for a write-back bundle: writes to r0
// are dropped, and when several lanes target the same register only the
// highest-numbered lane keeps its enable (program order within the bundle).
module mem_wb_lane_qual
    import mem_wb_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned REG_AW = 5
) (
    input  logic [LANES-1:0]        wen,
    input  logic [LANES*REG_AW-1:0] waddr,
    output logic [LANES-1:0]        wen_q
);

    // A lane survives if it writes a non-zero register nobody above it also writes.
    always_comb begin
        wen_q = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            wen_q[i] = wen[i] && (waddr[i*REG_AW +: REG_AW] != REG_AW'(REG_ZERO));
            for (int j = i + 1; j < int'(LANES); j++) begin
                if (wen[j] && (waddr[j*REG_AW +: REG_AW] == waddr[i*REG_AW +: REG_AW])) begin
                    wen_q[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage_n.sv
// MEM->WB pipeline register for LANES write-back slots with valid/allowin
// handshake, flush and write-enable qualification at capture.
// Optional macro MEM_WB_SKID_EN: adds a second (skid) entry so mem_allowin
// is registered and carries no combinational path from wb_allowin.
module mem_wb_stage_n
    import mem_wb_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input logic             clk,
    input logic             rsta,
    mem_wb_stage_n_if.slave bus
);

    typedef struct packed {
        logic [LANES*DATA_W-1:0] wdata;
        logic [LANES*REG_AW-1:0] waddr;
        logic [LANES-1:0]        wen;
        logic [LANES-1:0]        mul_en;
    } bundle_t;

    logic [LANES-1:0] cap_wen;
    bundle_t          cap_b;
    bundle_t          main_q;
    logic             main_vld;
    logic             accept;

    mem_wb_lane_qual #(
        .LANES  (LANES),
        .REG_AW (REG_AW)
    ) u_lane_qual (
        .wen   (bus.mem_wen),
        .waddr (bus.mem_waddr),
        .wen_q (cap_wen)
    );

    // Bundle as it will be stored: enables already qualified.
    always_comb begin
        cap_b.wdata  = bus.mem_wdata;
        cap_b.waddr  = bus.mem_waddr;
        cap_b.wen    = cap_wen;
        cap_b.mul_en = bus.mem_mul_en;
    end

`ifdef MEM_WB_SKID_EN
    skid_state_e state_q;
    bundle_t     skid_q;
    logic        consume;

    assign bus.mem_allowin = (state_q != StTwo);
    assign main_vld        = (state_q != StEmpty);
    assign accept          = bus.mem_valid && bus.mem_allowin;
    assign consume         = main_vld && bus.wb_allowin;

    // Occupancy FSM: main feeds WB, skid catches the one bundle accepted during a stall.
    always_ff @(posedge clk) begin
        if (!rsta) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (bus.flush) begin
            state_q <= StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_q  <= cap_b;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (accept && consume) begin
                        main_q <= cap_b;
                    end else if (accept) begin
                        skid_q  <= cap_b;
                        state_q <= StTwo;
                    end else if (consume) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    // mem_allowin is low here, so only a consume can happen.
                    if (consume) begin
                        main_q  <= skid_q;
                        state_q <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end
`else
    logic valid_q;

    assign main_vld        = valid_q;
    assign bus.mem_allowin = !valid_q || bus.wb_allowin;
    assign accept          = bus.mem_valid && bus.mem_allowin;

    // Single stage register: load on accept, empty on consume, flush wins over both.
    always_ff @(posedge clk) begin
        if (!rsta) begin
            valid_q <= 1'b0;
            main_q  <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            main_q  <= cap_b;
        end else if (bus.wb_allowin) begin
            valid_q <= 1'b0;
        end
    end
`endif

    // Stale data may remain after flush; gating wen keeps it harmless.
    assign bus.wb_valid  = main_vld;
    assign bus.wb_wdata  = main_q.wdata;
    assign bus.wb_waddr  = main_q.waddr;
    assign bus.wb_wen    = main_q.wen & {LANES{main_vld}};
    assign bus.wb_mul_en = main_q.mul_en;

endmodule
